// File: rtl/vc_arbiter.sv
// Round-robin scheduler moving words from four ingress VC FIFOs into one egress FIFO,
// with per-grant burst limiting and egress backpressure. Optional macro: VC_STRICT_PRIO_EN.
module vc_arbiter #(
    parameter int DATA_SIZE = 10,
    parameter int BURST     = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [3:0]             in_empty,
    input  logic [4*DATA_SIZE-1:0] in_data,
    input  logic                   out_pause,
    input  logic                   out_full,
    output logic [3:0]             in_pop,
    output logic                   out_push,
    output logic [DATA_SIZE-1:0]   out_data,
    output logic [1:0]             grant,
    output logic                   busy,
    output logic                   arb_error
);

    typedef enum logic [1:0] {IDLE, GRANT, STALL} state_t;

    localparam logic [3:0] BURST_LAST = 4'(BURST - 1);

    state_t     state_q, state_d;
    logic [1:0] grant_q, grant_d;
    logic [3:0] burst_cnt_q, burst_cnt_d;
    logic       pop_dly_q, pop_dly_d;
    logic [1:0] grant_dly_q, grant_dly_d;
    logic       arb_error_q, arb_error_d;

    logic       ok;
    logic       any_req;
    logic       pop_now;
    logic       burst_done;
    logic [1:0] pick;
    logic [1:0] cand;

    logic [DATA_SIZE-1:0] in_word [4];

    for (genvar g = 0; g < 4; g++) begin : g_word
        assign in_word[g] = in_data[g*DATA_SIZE +: DATA_SIZE];
    end

    assign ok      = !out_pause && !out_full;
    assign any_req = ~&in_empty;

    // Walk grant+4 down to grant+1 so the nearest non-empty requester wins;
    // grant+4 wraps to the current holder, which is how a lone requester is regranted.
    always_comb begin
        pick = grant_q;
        cand = grant_q;
        for (int k = 4; k >= 1; k--) begin
            cand = grant_q + 2'(k);
            if (!in_empty[cand]) pick = cand;
        end
`ifdef VC_STRICT_PRIO_EN
        if (!in_empty[0]) pick = 2'd0;
`endif
    end

`ifdef VC_STRICT_PRIO_EN
    assign burst_done = (burst_cnt_q == BURST_LAST) && (grant_q != 2'd0);
`else
    assign burst_done = (burst_cnt_q == BURST_LAST);
`endif

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        burst_cnt_d = burst_cnt_q;
        pop_now     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (any_req && ok) begin
                    state_d     = GRANT;
                    grant_d     = pick;
                    burst_cnt_d = '0;
                end
            end
            GRANT: begin
                if (!ok) begin
                    state_d = STALL;
                end else begin
                    pop_now = !in_empty[grant_q];
                    if (pop_now) burst_cnt_d = burst_cnt_q + 4'd1;
                    if (!pop_now || burst_done) begin
                        if (any_req) begin
                            grant_d     = pick;
                            burst_cnt_d = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            STALL: begin
                if (ok) state_d = in_empty[grant_q] ? IDLE : GRANT;
            end
            default: state_d = IDLE;
        endcase
    end

    assign pop_dly_d   = pop_now;
    assign grant_dly_d = grant_q;
    assign arb_error_d = arb_error_q | (out_push & out_full);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            grant_q     <= 2'd3;
            burst_cnt_q <= '0;
            pop_dly_q   <= 1'b0;
            grant_dly_q <= 2'd0;
            arb_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            burst_cnt_q <= burst_cnt_d;
            pop_dly_q   <= pop_dly_d;
            grant_dly_q <= grant_dly_d;
            arb_error_q <= arb_error_d;
        end
    end

    // Ingress data arrives one cycle after its pop, so the push is aligned to the delayed grant.
    assign in_pop    = (pop_now && !reset) ? (4'b0001 << grant_q) : 4'b0000;
    assign out_push  = pop_dly_q && !reset;
    assign out_data  = out_push ? in_word[grant_dly_q] : '0;
    assign grant     = grant_q;
    assign busy      = (state_q == GRANT) || (state_q == STALL);
    assign arb_error = arb_error_q;

endmodule

// File: tb/tb_vc_arbiter.sv
// Bench for vc_arbiter: queue-based ingress FIFOs, a rule-level scheduler model checked
// every cycle, and directed scenarios with hand-computed pop/push sequences.
module tb_vc_arbiter;

    localparam int DW    = 10;
    localparam int BURST = 4;
    localparam int P_IDLE = 0, P_SERVE = 1, P_HOLD = 2;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [3:0]      in_empty = 4'hF;
    logic [4*DW-1:0] in_data;
    logic            out_pause = 1'b0;
    logic            out_full = 1'b0;
    logic [3:0]      in_pop;
    logic            out_push;
    logic [DW-1:0]   out_data;
    logic [1:0]      grant;
    logic            busy;
    logic            arb_error;

    always #5 clk = ~clk;

    vc_arbiter #(.DATA_SIZE(DW), .BURST(BURST)) dut (
        .clk(clk), .reset(reset), .in_empty(in_empty), .in_data(in_data),
        .out_pause(out_pause), .out_full(out_full), .in_pop(in_pop),
        .out_push(out_push), .out_data(out_data), .grant(grant),
        .busy(busy), .arb_error(arb_error)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Ingress FIFOs: a pop presents its word on in_data the following cycle.
    logic [DW-1:0] fq [4][$];
    logic [DW-1:0] dout [4] = '{default: '0};
    logic [3:0]    pop_s = 4'b0;

    for (genvar g = 0; g < 4; g++) begin : g_in
        assign in_data[g*DW +: DW] = dout[g];
    end

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (pop_s[i] && fq[i].size() > 0) dout[i] <= fq[i].pop_front();
            in_empty[i] <= (fq[i].size() == 0);
        end
    end

    // Scheduler model: phase, current holder, words left in its burst, word in flight.
    int phase = P_IDLE, mg = 3, left = 0, m_word = 0, cyc = 0;
    bit m_pend = 0, m_err = 0, m_init = 0;
    int pop_log[$], pop_cyc[$], push_log[$], push_cyc[$];

    function automatic int m_pick(input logic [3:0] emp, input int cur);
`ifdef VC_STRICT_PRIO_EN
        if (!emp[0]) return 0;
`endif
        for (int k = 1; k <= 4; k++)
            if (!emp[(cur + k) % 4]) return (cur + k) % 4;
        return cur;
    endfunction

    function automatic int m_limit(input int g);
`ifdef VC_STRICT_PRIO_EN
        if (g == 0) return 1 << 30;
`endif
        return BURST;
    endfunction

    always @(negedge clk) begin
        bit         ok;
        logic [3:0] exp_pop;
        cyc++;
        pop_s = in_pop;
        for (int i = 0; i < 4; i++)
            if (in_pop[i]) begin pop_log.push_back(i); pop_cyc.push_back(cyc); end
        if (out_push) begin push_log.push_back(int'(out_data)); push_cyc.push_back(cyc); end
        if (reset) begin
            check("rst_in_pop", int'(in_pop), 0);
            check("rst_out_push", int'(out_push), 0);
            check("rst_out_data", int'(out_data), 0);
            phase = P_IDLE; mg = 3; left = 0; m_pend = 0; m_err = 0; m_word = 0; m_init = 1;
        end else if (m_init) begin
            ok = !out_pause && !out_full;
            exp_pop = (phase == P_SERVE && ok && !in_empty[mg]) ? 4'(1 << mg) : 4'b0;
            check("in_pop", int'(in_pop), int'(exp_pop));
            check("out_push", int'(out_push), int'(m_pend));
            check("out_data", int'(out_data), m_pend ? m_word : 0);
            check("grant", int'(grant), mg);
            check("busy", int'(busy), int'(phase != P_IDLE));
            check("arb_error", int'(arb_error), int'(m_err));
            if (m_pend && out_full) m_err = 1;
            m_pend = (exp_pop != 0);
            if (m_pend) m_word = int'(fq[mg][0]);
            case (phase)
                P_IDLE: if (in_empty != 4'hF && ok) begin
                    mg = m_pick(in_empty, mg); left = m_limit(mg); phase = P_SERVE;
                end
                P_SERVE: if (!ok) phase = P_HOLD;
                else begin
                    if (m_pend) left--;
                    if (!m_pend || left == 0) begin
                        if (in_empty != 4'hF) begin mg = m_pick(in_empty, mg); left = m_limit(mg); end
                        else phase = P_IDLE;
                    end
                end
                default: if (ok) phase = in_empty[mg] ? P_IDLE : P_SERVE;
            endcase
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic clear_logs();
        pop_log.delete(); pop_cyc.delete(); push_log.delete(); push_cyc.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) fq[i].delete();
        tick(2);
        reset = 1'b0;
        check("rst_grant", int'(grant), 3);
        check("rst_busy", int'(busy), 0);
        check("rst_arb_error", int'(arb_error), 0);
        clear_logs();
    endtask

    task automatic load(input int i, input int n, input int base);
        for (int k = 0; k < n; k++) fq[i].push_back(DW'(base + k));
    endtask

    task automatic wait_pops(input int n);
        for (int k = 0; k < 100 && pop_log.size() < n; k++) tick();
        check("wait_pops", pop_log.size(), n);
    endtask

    initial begin
        int exp6 [12];

        // Single requester, three words
        do_reset();
        load(0, 3, 'h0A1);
        tick(10);
        check("t1_pops", pop_log.size(), 3);
        for (int k = 0; k < 3; k++) begin
            check("t1_pop_idx", pop_log[k], 0);
            check("t1_data", push_log[k], 'h0A1 + k);
        end
        check("t1_grant", int'(grant), 0);
        check("t1_busy", int'(busy), 0);

        // All four full: bursts of four in round-robin order, no bubbles
        do_reset();
        for (int i = 0; i < 4; i++) load(i, 8, i * 100 + 1);
        tick(45);
        check("t2_pops", pop_log.size(), 32);
        check("t2_pushes", push_log.size(), 32);
        for (int k = 0; k < 32; k++) begin
            check("t2_pop_idx", pop_log[k], (k / 4) % 4);
            check("t2_data", push_log[k], ((k / 4) % 4) * 100 + (k / 16) * 4 + k % 4 + 1);
        end
        check("t2_no_bubble", push_cyc[31] - push_cyc[0], 31);

        // Pause for five cycles after two pops of requester 1
        do_reset();
        load(1, 6, 'h110);
        load(2, 4, 'h220);
        wait_pops(2);
        out_pause = 1'b1;
        tick(5);
        out_pause = 1'b0;
        tick(25);
        exp6 = '{1, 1, 1, 1, 2, 2, 2, 2, 1, 1, 0, 0};
        check("t3_pops", pop_log.size(), 10);
        for (int k = 0; k < 10; k++) check("t3_pop_idx", pop_log[k], exp6[k]);
        check("t3_trailing_push", push_cyc[1] - pop_cyc[1], 1);
        check("t3_pause_gap", pop_cyc[2] - pop_cyc[1], 7);
        check("t3_push_gap", push_cyc[2] - push_cyc[1], 7);

        // Granted FIFO runs dry after one word; requester 3 takes over
        do_reset();
        load(0, 1, 'h301);
        load(3, 3, 'h331);
        tick(12);
        exp6 = '{0, 3, 3, 3, 0, 0, 0, 0, 0, 0, 0, 0};
        check("t4_pops", pop_log.size(), 4);
        for (int k = 0; k < 4; k++) check("t4_pop_idx", pop_log[k], exp6[k]);
        check("t4_switch_gap", pop_cyc[1] - pop_cyc[0], 2);
        check("t4_grant", int'(grant), 3);

        // Push into a full egress FIFO sets the sticky error; reset mid-burst clears it
        do_reset();
        load(2, 6, 'h201);
        wait_pops(1);
        out_full = 1'b1;
        tick(2);
        check("t5_err_set", int'(arb_error), 1);
        out_full = 1'b0;
        tick(1);
        check("t5_err_sticky", int'(arb_error), 1);
        wait_pops(3);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("t5_err_cleared", int'(arb_error), 0);
        check("t5_no_push_after_rst", int'(out_push), 0);
        tick(20);

        // Requesters 0 and 2 with six words each
        do_reset();
        load(0, 6, 'h001);
        load(2, 6, 'h201);
        tick(25);
`ifdef VC_STRICT_PRIO_EN
        exp6 = '{0, 0, 0, 0, 0, 0, 2, 2, 2, 2, 2, 2};
`else
        exp6 = '{0, 0, 0, 0, 2, 2, 2, 2, 0, 0, 2, 2};
`endif
        check("t6_pops", pop_log.size(), 12);
        for (int k = 0; k < 12; k++) check("t6_pop_idx", pop_log[k], exp6[k]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vc_arbiter.md
Name: vc_arbiter

Overview:
- Round-robin scheduler that shares one egress FIFO among 4 ingress (virtual-channel) FIFOs in the PCIe switch datapath.
- Pops ingress FIFOs through their read strobes and pushes the popped word into the egress FIFO.
- Honours egress backpressure (pause/full) and limits each grant to a burst of at most BURST words.

Parameters:
- DATA_SIZE, 10, width of one FIFO word.
- BURST, 4, max consecutive pops per grant; legal range 1..15.

Ports:
- clk  input  1  clock; all logic on posedge clk.
- reset  input  1  synchronous, active-high reset.
- in_empty  input  4  fifo_empty flag of ingress FIFO i (bit i).
- in_data  input  4*DATA_SIZE  data_out_pop of ingress FIFO i at bits [i*DATA_SIZE +: DATA_SIZE]; valid the cycle after its pop.
- out_pause  input  1  egress fifo_pause (almost full).
- out_full  input  1  egress Fifo_full.
- in_pop  output  4  read strobe to ingress FIFO i; one-hot or zero.
- out_push  output  1  write strobe to egress FIFO.
- out_data  output  DATA_SIZE  word presented with out_push.
- grant  output  2  index of the currently granted requester.
- busy  output  1  high when state is GRANT or STALL.
- arb_error  output  1  sticky overflow flag.

Behaviour:
- Reset (reset=1 at a clock edge):
  - state=IDLE, grant=3 (so the first arbitration starts at 0), burst_cnt=0, pop_d=0, grant_d=0, arb_error=0.
  - All strobes 0 during reset; out_data=0.
  - Reset mid-burst discards the in-flight push: no out_push in the cycle after reset.
- ok = !out_pause && !out_full.
- Round-robin pick: first i with in_empty[i]=0, searching grant+1, grant+2, grant+3, grant (mod 4).
- IDLE:
  - If any in_empty=0 and ok: grant<=pick, burst_cnt<=0, go GRANT. No pop in this cycle.
  - Otherwise stay in IDLE.
- GRANT: in_pop[grant] = !in_empty[grant] && ok (combinational); each pop increments burst_cnt.
  - If !ok: go STALL; grant and burst_cnt are held.
  - If a pop occurs with burst_cnt==BURST-1, or in_empty[grant]=1 (no pop): re-arbitrate.
    - If another requester is non-empty: grant<=pick, burst_cnt<=0, stay in GRANT. New grant pops from the next cycle.
    - If none is non-empty: go IDLE.
  - A lone requester that hits the burst limit is regranted itself with burst_cnt reset (pick wraps to grant).
- STALL: no pops.
  - When ok returns: go GRANT if in_empty[grant]=0, else IDLE.
- Push pipeline:
  - pop_d <= |in_pop; grant_d <= grant.
  - out_push = pop_d; out_data = in_data slice grant_d when pop_d, else 0.
  - Latency pop -> push is exactly 1 cycle.
  - A pop issued in the cycle pause rises still produces its push next cycle; the egress almost-full threshold provides the slack.
- arb_error is set when out_push=1 && out_full=1 in the same cycle. It stays set until reset.
- Throughput: 1 word/clock while the granted FIFO is non-empty and ok holds; one bubble per grant change out of IDLE only.

Optional Feature:
- Macro VC_STRICT_PRIO_EN.
- When defined:
  - Requester 0 has strict priority: whenever in_empty[0]=0 at any re-arbitration or IDLE exit, grant=0 regardless of round-robin order.
  - Requester 0's burst limit is ignored; it holds grant until empty or stalled.
  - Requesters 1..3 remain round-robin among themselves.
- When undefined: pure round-robin as above for all four.

Test Plan:
- Reset, then in_empty=4'b1110 with ingress 0 holding 3 words A,B,C, ok=1 -> one IDLE cycle, then in_pop=0001 for 3 cycles; out_push for 3 cycles one clock later with out_data A,B,C; state returns to IDLE; grant=0.
- All four FIFOs hold 8 words, BURST=4 -> pop sequence 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0...; out_push continuous with no bubbles after the first.
- out_pause asserted for 5 cycles mid-burst (after 2 pops of requester 1) -> in_pop=0 during the pause and exactly one trailing out_push; after release, requester 1 pops its 2 remaining burst words before grant moves to 2.
- Granted FIFO empties after 1 word while requester 3 is non-empty -> grant switches to 3 the next cycle and pops continue; no pop is issued to the empty FIFO.
- out_full rises in the same cycle as a pop -> out_push next cycle with out_full=1 sets arb_error=1; it stays 1 until reset=1 for one clock clears it to 0.
- With VC_STRICT_PRIO_EN, requesters 0 and 2 are both non-empty (6 words each), BURST=4 -> all 6 words of requester 0 pop first, then requester 2.
